ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//   Execute-stage RV32M multiply/divide unit, consuming operands and control held in the ID/EX register.
//   Iterative shift-add multiply and restoring divide, one result bit per cycle.
//   Raises BusyE so the hazard unit stalls F/D/E while an operation runs.
//   Result is muxed into the EX result path when ValidE is high.
// PARAMETERS
//   DATA_WIDTH  32  operand/result width; only 32 is supported
// PORTS
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   Flush      in   1   kills any in-flight op; same flush as the ID/EX register
//   StartE     in   1   EX holds an M-extension op (held high while stalled)
//   FunctE     in   3   funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   SrcAE      in   32  forwarded rs1 value
//   SrcBE      in   32  forwarded rs2 value
//   BusyE      out  1   stall request (combinational)
//   ValidE     out  1   ResultE valid this cycle; one-cycle pulse
//   ResultE    out  32  result; holds its value until the next completion
// BEHAVIOUR
//   Clock/reset: one clock (clk); reset is asynchronous, active-high (rst).
//   Reset: state IDLE; ResultE=0; ValidE=0; BusyE=0 while rst is high.
//   Reset mid-operation aborts the op with no ValidE.
//   States:
//     IDLE -> MUL|DIV when StartE && !Flush. Special-case divides go IDLE -> DONE.
//     MUL|DIV -> DONE when the 5-bit counter reaches 0.
//     DONE -> IDLE unconditionally.
//   Start cycle t:
//     - latch |A|, |B| (signedness per FunctE) and the result-sign flags; count=31.
//     - later changes to SrcAE/SrcBE/FunctE are ignored.
//   Iteration: cycles t+1..t+32, one bit each. DONE at t+33: ValidE=1, ResultE updated.
//   BusyE = (IDLE && StartE && !Flush) || MUL || DIV. So BusyE is high t..t+32 (33 cycles), low in DONE.
//   StartE is ignored in DONE: the stalled instruction now advances, so there is no restart.
//     A new StartE is accepted from t+34 (IDLE).
//   MUL:
//     - 64-bit shift-add on magnitudes; negate the product if the signs differ.
//     - MULHSU treats only A as signed.
//     - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
//   DIV:
//     - restoring divide on magnitudes.
//     - quotient sign = sign(A) xor sign(B); remainder takes the sign of the dividend.
//   Special divides are detected at start and give DONE at t+1 (BusyE only at t):
//     - B==0: quotient = 0xFFFFFFFF; remainder = A.
//     - signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
//   Flush (synchronous):
//     - any state -> IDLE; ValidE stays 0; ResultE unchanged.
//     - Flush with StartE in IDLE starts nothing; BusyE=0.
//   All arithmetic is modulo 2^32 (2^64 for the internal product). No exceptions are raised.
// CONFIGURATION
//   MULDIV_FAST_MUL_EN
//     defined: MUL* ops use a combinational 33x33 signed multiply. Latched at t, DONE at t+1, BusyE high only at t.
//     undefined: the iterative 33-cycle multiply above. Divide behaviour is identical either way.
// TESTING
//   1. DIV 100 / 0xFFFFFFF9 (-7) -> ResultE 0xFFFFFFF2. BusyE high 33 cycles; ValidE at t+33 only.
//   2. REM 0xFFFFFF9C (-100) % 7 -> 0xFFFFFFFE. REMU 0xFFFFFFFF % 10 -> 5.
//   3. Special divides, ValidE at t+1:
//      - DIVU 5/0 -> 0xFFFFFFFF; REM 123 % 0 -> 123.
//      - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
//   4. Multiplies:
//      - MUL 7 * 0xFFFFFFFD -> 0xFFFFFFEB.
//      - MULH 0x80000000 * 0x80000000 -> 0x40000000.
//      - MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
//      - MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
//      - Repeat with MULDIV_FAST_MUL_EN: same values, ValidE at t+1.
//   5. Aborts:
//      - Flush at t+10 of a DIV -> IDLE at t+11, ValidE never set, ResultE keeps its prior value.
//      - rst at t+5 -> all outputs 0 at once.
//   6. StartE held high from t through t+33 -> exactly one ValidE pulse (t+33).
//      A new DIV started at t+34 completes at t+67.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Execute-stage RV32M multiply/divide: iterative shift-add multiply and restoring divide.
// Optional MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle multiplier.
module ex_muldiv_unit #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Flush,
   input  logic                  StartE,
   input  logic [2:0]            FunctE,
   input  logic [DATA_WIDTH-1:0] SrcAE,
   input  logic [DATA_WIDTH-1:0] SrcBE,
   output logic                  BusyE,
   output logic                  ValidE,
   output logic [DATA_WIDTH-1:0] ResultE
);

   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned CW = $clog2(W);
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t          state, state_d;
   logic [2*W-1:0]  p, p_d;           // mul: {hi, multiplier}; div: {remainder, quotient}
   logic [W-1:0]    m, m_d;           // multiplicand or divisor magnitude
   logic [CW-1:0]   cnt, cnt_d;
   logic [2:0]      fn, fn_d;
   logic            neg, neg_d;
   logic            valid_d;
   logic [W-1:0]    result_d;

   logic            start, a_sgn, b_sgn, a_neg, b_neg;
   logic [W-1:0]    a_abs, b_abs;
   logic [W:0]      msum, dshift, ddiff;
   logic [2*W-1:0]  p_mul, prod;
   logic [W-1:0]    r_n, q_n, dres;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*W-1:0]  fprod;
`endif

   assign start = (state == S_IDLE) && StartE && !Flush;
   assign BusyE = !rst && (start || (state == S_MUL) || (state == S_DIV));

   // Next-state and datapath
   always_comb begin
      state_d  = state;
      p_d      = p;
      m_d      = m;
      cnt_d    = cnt;
      fn_d     = fn;
      neg_d    = neg;
      valid_d  = 1'b0;
      result_d = ResultE;

      // MULHU, DIVU, REMU are fully unsigned; MULHSU only treats A as signed
      a_sgn = (FunctE != 3'd3) && !(FunctE[2] && FunctE[0]);
      b_sgn = a_sgn && (FunctE != 3'd2);
      a_neg = a_sgn && SrcAE[W-1];
      b_neg = b_sgn && SrcBE[W-1];
      a_abs = a_neg ? -SrcAE : SrcAE;
      b_abs = b_neg ? -SrcBE : SrcBE;

      msum  = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, m} : '0);
      p_mul = {msum, p[W-1:1]};
      prod  = neg ? -p_mul : p_mul;

      dshift = {p[2*W-1:W], p[W-1]};
      ddiff  = dshift - {1'b0, m};
      if (!ddiff[W]) begin
         r_n = ddiff[W-1:0];
         q_n = {p[W-2:0], 1'b1};
      end else begin
         r_n = dshift[W-1:0];
         q_n = {p[W-2:0], 1'b0};
      end
      dres = fn[1] ? r_n : q_n;

`ifdef MULDIV_FAST_MUL_EN
      fprod = {{W{a_neg}}, SrcAE} * {{W{b_neg}}, SrcBE};
`endif

      case (state)
         S_IDLE: begin
            if (start) begin
               fn_d  = FunctE;
               cnt_d = CW'(W - 1);
               if (FunctE[2]) begin
                  neg_d = FunctE[1] ? a_neg : (a_neg ^ b_neg);
                  if (SrcBE == '0) begin
                     result_d = FunctE[1] ? SrcAE : '1;
                     valid_d  = 1'b1;
                     state_d  = S_DONE;
                  end else if (!FunctE[0] && (SrcAE == MIN_NEG) && (SrcBE == '1)) begin
                     result_d = FunctE[1] ? '0 : MIN_NEG;
                     valid_d  = 1'b1;
                     state_d  = S_DONE;
                  end else begin
                     p_d     = {{W{1'b0}}, a_abs};
                     m_d     = b_abs;
                     state_d = S_DIV;
                  end
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  result_d = (FunctE[1:0] == 2'd0) ? fprod[W-1:0] : fprod[2*W-1:W];
                  valid_d  = 1'b1;
                  state_d  = S_DONE;
`else
                  neg_d   = a_neg ^ b_neg;
                  p_d     = {{W{1'b0}}, b_abs};
                  m_d     = a_abs;
                  state_d = S_MUL;
`endif
               end
            end
         end
         S_MUL: begin
            p_d   = p_mul;
            cnt_d = CW'(cnt - 1'b1);
            if (cnt == '0) begin
               result_d = (fn[1:0] == 2'd0) ? prod[W-1:0] : prod[2*W-1:W];
               valid_d  = 1'b1;
               state_d  = S_DONE;
            end
         end
         S_DIV: begin
            p_d   = {r_n, q_n};
            cnt_d = CW'(cnt - 1'b1);
            if (cnt == '0) begin
               result_d = neg ? -dres : dres;
               valid_d  = 1'b1;
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Flush kills whatever is in flight, including a same-cycle completion
      if (Flush) begin
         state_d  = S_IDLE;
         valid_d  = 1'b0;
         result_d = ResultE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         p       <= '0;
         m       <= '0;
         cnt     <= '0;
         fn      <= '0;
         neg     <= 1'b0;
         ValidE  <= 1'b0;
         ResultE <= '0;
      end else begin
         state   <= state_d;
         p       <= p_d;
         m       <= m_d;
         cnt     <= cnt_d;
         fn      <= fn_d;
         neg     <= neg_d;
         ValidE  <= valid_d;
         ResultE <= result_d;
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (iterative or MULDIV_FAST_MUL_EN build).
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        Flush;
   logic        StartE;
   logic [2:0]  FunctE;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic        BusyE;
   logic        ValidE;
   logic [31:0] ResultE;

   int checks = 0;
   int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .Flush   (Flush),
      .StartE  (StartE),
      .FunctE  (FunctE),
      .SrcAE   (SrcAE),
      .SrcBE   (SrcBE),
      .BusyE   (BusyE),
      .ValidE  (ValidE),
      .ResultE (ResultE)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
      end
   endtask

   // Called just after a rising edge; that cycle is t. StartE is held t..t+lat.
   task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit tail);
      int done   = -1;
      int nvalid = 0;
      int nbusy  = 0;
      logic [31:0] res = 'x;
      StartE = 1'b1;
      FunctE = f;
      SrcAE  = a;
      SrcBE  = b;
      for (int i = 0; i <= lat; i++) begin
         @(negedge clk);
         if (BusyE) nbusy++;
         if (ValidE) begin
            nvalid++;
            if (done < 0) begin
               done = i;
               res  = ResultE;
            end
         end
         @(posedge clk);
         #1;
         if (i == 0) begin
            SrcAE  = ~a;
            SrcBE  = ~b;
            FunctE = ~f;
         end
         if (i == lat) StartE = 1'b0;
      end
      check({tag, " result"}, res, exp);
      check({tag, " valid_cycle"}, 32'(done), 32'(lat));
      check({tag, " valid_pulses"}, 32'(nvalid), 32'd1);
      check({tag, " busy_cycles"}, 32'(nbusy), 32'(lat));
      if (tail) begin
         @(negedge clk);
         check({tag, " idle_after"}, {30'd0, BusyE, ValidE}, 32'd0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int nv;
      logic [31:0] prior;
      rst    = 1'b1;
      Flush  = 1'b0;
      StartE = 1'b0;
      FunctE = 3'd0;
      SrcAE  = '0;
      SrcBE  = '0;
      repeat (2) @(posedge clk);
      #1;
      StartE = 1'b1;
      FunctE = 3'd4;
      SrcAE  = 32'd9;
      SrcBE  = 32'd3;
      #1;
      check("reset outputs", {ResultE[31:2], BusyE, ValidE}, 32'd0);
      check("reset result", ResultE, 32'd0);
      StartE = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Divides and remainders
      do_op("div_neg",   3'd4, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2, DIV_LAT, 1'b1);
      do_op("rem_neg",   3'd6, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFFE, DIV_LAT, 1'b1);
      do_op("remu",      3'd7, 32'hFFFFFFFF,   32'd10,       32'd5,        DIV_LAT, 1'b1);
      do_op("divu",      3'd5, 32'hFFFFFFFF,   32'd16,       32'h0FFFFFFF, DIV_LAT, 1'b1);

      // Special divides
      do_op("divu_by0",  3'd5, 32'd5,          32'd0,        32'hFFFFFFFF, 1, 1'b1);
      do_op("rem_by0",   3'd6, 32'd123,        32'd0,        32'd123,      1, 1'b1);
      do_op("div_ovf",   3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1, 1'b1);
      do_op("rem_ovf",   3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1, 1'b1);

      // Multiplies
      do_op("mul",       3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, 1'b1);
      do_op("mulh",      3'd1, 32'h80000000,   32'h80000000, 32'h40000000, MUL_LAT, 1'b1);
      do_op("mulhu",     3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, 1'b1);
      do_op("mulhsu",    3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 1'b1);
      do_op("mulh_mix",  3'd1, 32'hFFFFFFFE,   32'd3,        32'hFFFFFFFF, MUL_LAT, 1'b1);

      // Flush at t+10 of a DIV
      prior  = 32'hFFFFFFFF;
      StartE = 1'b1;
      FunctE = 3'd4;
      SrcAE  = 32'd1000;
      SrcBE  = 32'd3;
      repeat (10) @(posedge clk);
      #1;
      Flush = 1'b1;
      @(posedge clk);
      #1;
      Flush  = 1'b0;
      StartE = 1'b0;
      @(negedge clk);
      check("flush busy", {31'd0, BusyE}, 32'd0);
      nv = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ValidE) nv++;
      end
      check("flush no_valid", 32'(nv), 32'd0);
      check("flush result_kept", ResultE, prior);

      // Flush together with StartE in IDLE starts nothing
      @(posedge clk);
      #1;
      Flush  = 1'b1;
      StartE = 1'b1;
      @(negedge clk);
      check("flush_start busy", {31'd0, BusyE}, 32'd0);
      @(posedge clk);
      #1;
      Flush  = 1'b0;
      StartE = 1'b0;
      @(negedge clk);
      check("flush_start idle", {30'd0, BusyE, ValidE}, 32'd0);

      // Reset at t+5 of a DIV
      @(posedge clk);
      #1;
      StartE = 1'b1;
      FunctE = 3'd4;
      SrcAE  = 32'd50;
      SrcBE  = 32'd5;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid outputs", {30'd0, BusyE, ValidE}, 32'd0);
      check("rst_mid result", ResultE, 32'd0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      StartE = 1'b0;
      nv = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ValidE) nv++;
      end
      check("rst_mid no_valid", 32'(nv), 32'd0);
      @(posedge clk);
      #1;

      // Back-to-back: second DIV accepted at t+34, completes at t+67
      do_op("b2b_first",  3'd4, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, DIV_LAT, 1'b0);
      do_op("b2b_second", 3'd4, 32'd77,  32'd7,        32'd11,       DIV_LAT, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
